// File: rtl/screenchar_pkg.sv
// Shared constants, FSM encoding and character rendering helper for the
// screen character sweep writer and its digit converter.
package screenchar_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_NINE  = 8'h39;

   localparam int DEF_NUM_FIELDS  = 2;
   localparam int DEF_DIGITS      = 5;
   localparam int DEF_NUM_CLIENTS = 2;
   localparam int DEF_ADDR_W      = 8;
   localparam int DEF_TIMEOUT     = 1024;

   // A 32-bit value never needs more than ten decimal digits.
   localparam int BCD_MAX_DIGITS  = 10;

   typedef enum logic [2:0] {
      IDLE,
      F_LOAD,
      F_CONV,
      F_WRITE,
      C_START,
      C_WAIT,
      DONE
   } state_e;

   function automatic logic [7:0] digit_char(input logic [3:0] nib,
                                             input logic       blank,
                                             input logic       sat);
      logic [7:0] c;
      if (sat)
         c = ASCII_NINE;
      else if (blank && (nib == 4'd0))
         c = ASCII_SPACE;
      else
         c = ASCII_ZERO + {4'h0, nib};
      return c;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: 32-bit binary to DIGITS BCD digits,
// one shift per cycle, with an overflow flag for values wider than DIGITS.
module bin_to_bcd_seq
   import screenchar_pkg::*;
#(
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                start,
   input  logic [31:0]         value,
   output logic                done,
   output logic [DIGITS*4-1:0] bcd,
   output logic                ovf
);

   localparam int BW = BCD_MAX_DIGITS * 4;

   logic          busy_q;
   logic          done_q;
   logic [5:0]    cnt_q;
   logic [31:0]   bin_q;
   logic [BW-1:0] acc_q;
   logic [BW-1:0] adj;

   function automatic logic [BW-1:0] dabble(input logic [BW-1:0] a);
      logic [BW-1:0] r;
      r = a;
      for (int i = 0; i < BCD_MAX_DIGITS; i++)
         if (r[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      return r;
   endfunction

   assign adj = dabble(acc_q);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         done_q <= 1'b0;
         cnt_q  <= 6'd32;
      end else if (busy_q) begin
         cnt_q <= cnt_q - 6'd1;
         if (cnt_q == 6'd1) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   // Datapath carries no reset; it is only observed after done.
   always_ff @(posedge clock) begin
      if (start) begin
         bin_q <= value;
         acc_q <= '0;
      end else if (busy_q) begin
         bin_q <= {bin_q[30:0], 1'b0};
         acc_q <= {adj[BW-2:0], bin_q[31]};
      end
   end

   assign done = done_q;
   assign bcd  = acc_q[DIGITS*4-1:0];
   assign ovf  = |acc_q[BW-1:DIGITS*4];

endmodule

// File: rtl/screenchar_sweep_writer.sv
// Sweeps numeric fields into decimal characters, then services tracker
// clients, funnelling everything into one registered character-memory write port.
module screenchar_sweep_writer
   import screenchar_pkg::*;
#(
   parameter int NUM_FIELDS  = DEF_NUM_FIELDS,
   parameter int DIGITS      = DEF_DIGITS,
   parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          run,
   input  logic                          blank_lead,
   input  logic                          dirty_only,
   input  logic [NUM_FIELDS*32-1:0]      field_value,
   input  logic [NUM_FIELDS*ADDR_W-1:0]  field_base,
   output logic [NUM_CLIENTS-1:0]        cl_start,
   input  logic [NUM_CLIENTS-1:0]        cl_finish,
   input  logic [NUM_CLIENTS-1:0]        cl_valid,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_index,
   input  logic [NUM_CLIENTS*8-1:0]      cl_data,
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [7:0]                    wr_data,
   output logic                          busy,
   output logic                          sweep_done,
   output logic                          timeout_err
);

   localparam int FW = (NUM_FIELDS > 1)  ? $clog2(NUM_FIELDS)  : 1;
   localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int DW = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [FW-1:0]       fidx_q, fidx_d;
   logic [CW-1:0]       cidx_q, cidx_d;
   logic [DW-1:0]       dig_q, dig_d;
   logic                seen_q, seen_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic                terr_q, terr_d;
   logic [NUM_FIELDS-1:0] lv_q, lv_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic [31:0]         val_q;
   logic [31:0]         last_q [NUM_FIELDS];
   logic                upd_last;

   logic                conv_start;
   logic                conv_done;
   logic [DIGITS*4-1:0] conv_bcd;
   logic                conv_ovf;

   logic [31:0]         cur_val, cur_last;
   logic [ADDR_W-1:0]   cur_base, act_index;
   logic                cur_lv, act_valid, act_finish;
   logic [7:0]          act_data;
   logic [3:0]          nib;
   logic                last_field, last_client, last_digit;

   bin_to_bcd_seq #(.DIGITS(DIGITS)) u_conv (
      .clock  (clock),
      .resetn (resetn),
      .start  (conv_start),
      .value  (cur_val),
      .done   (conv_done),
      .bcd    (conv_bcd),
      .ovf    (conv_ovf)
   );

   always_comb begin
      cur_val    = '0;
      cur_base   = '0;
      cur_last   = '0;
      cur_lv     = 1'b0;
      act_valid  = 1'b0;
      act_finish = 1'b0;
      act_index  = '0;
      act_data   = '0;
      nib        = '0;
      for (int i = 0; i < NUM_FIELDS; i++)
         if (fidx_q == FW'(i)) begin
            cur_val  = field_value[i*32 +: 32];
            cur_base = field_base[i*ADDR_W +: ADDR_W];
            cur_last = last_q[i];
            cur_lv   = lv_q[i];
         end
      for (int i = 0; i < NUM_CLIENTS; i++)
         if (cidx_q == CW'(i)) begin
            act_valid  = cl_valid[i];
            act_finish = cl_finish[i];
            act_index  = cl_index[i*ADDR_W +: ADDR_W];
            act_data   = cl_data[i*8 +: 8];
         end
      // Digit counter runs MSD first, so digit i sits at nibble DIGITS-1-i.
      for (int i = 0; i < DIGITS; i++)
         if (dig_q == DW'(i))
            nib = conv_bcd[(DIGITS-1-i)*4 +: 4];
   end

   assign last_field  = (fidx_q == FW'(NUM_FIELDS - 1));
   assign last_client = (cidx_q == CW'(NUM_CLIENTS - 1));
   assign last_digit  = (dig_q == DW'(DIGITS - 1));

   always_comb begin
      state_d    = state_q;
      fidx_d     = fidx_q;
      cidx_d     = cidx_q;
      dig_d      = dig_q;
      seen_d     = seen_q;
      tmo_d      = tmo_q;
      terr_d     = terr_q;
      lv_d       = lv_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      conv_start = 1'b0;
      upd_last   = 1'b0;

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = F_LOAD;
               fidx_d  = '0;
            end
         end
         F_LOAD: begin
            if (dirty_only && cur_lv && (cur_val == cur_last)) begin
               if (last_field) begin
                  state_d = C_START;
                  cidx_d  = '0;
               end else begin
                  fidx_d = fidx_q + FW'(1);
               end
            end else begin
               conv_start = 1'b1;
               state_d    = F_CONV;
            end
         end
         F_CONV: begin
            if (conv_done) begin
               state_d = F_WRITE;
               dig_d   = '0;
               seen_d  = 1'b0;
            end
         end
         F_WRITE: begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_base + ADDR_W'(dig_q);
            wr_data_d = digit_char(nib, blank_lead && !seen_q && !last_digit, conv_ovf);
            seen_d    = seen_q | (nib != 4'd0);
            if (last_digit) begin
               upd_last = 1'b1;
               for (int i = 0; i < NUM_FIELDS; i++)
                  if (fidx_q == FW'(i))
                     lv_d[i] = 1'b1;
               if (last_field) begin
                  state_d = C_START;
                  cidx_d  = '0;
               end else begin
                  state_d = F_LOAD;
                  fidx_d  = fidx_q + FW'(1);
               end
            end else begin
               dig_d = dig_q + DW'(1);
            end
         end
         C_START: begin
            tmo_d   = '0;
            state_d = C_WAIT;
         end
         C_WAIT: begin
            if (act_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = act_index;
               wr_data_d = act_data;
            end
            if (act_finish || (tmo_q == TW'(TIMEOUT - 1))) begin
               if (!act_finish)
                  terr_d = 1'b1;
               if (last_client) begin
                  state_d = DONE;
               end else begin
                  state_d = C_START;
                  cidx_d  = cidx_q + CW'(1);
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         DONE: begin
            if (run) begin
               state_d = F_LOAD;
               fidx_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         fidx_q    <= '0;
         cidx_q    <= '0;
         dig_q     <= '0;
         seen_q    <= 1'b0;
         tmo_q     <= '0;
         terr_q    <= 1'b0;
         lv_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         fidx_q    <= fidx_d;
         cidx_q    <= cidx_d;
         dig_q     <= dig_d;
         seen_q    <= seen_d;
         tmo_q     <= tmo_d;
         terr_q    <= terr_d;
         lv_q      <= lv_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Value storage needs no reset: validity is tracked by lv_q.
   always_ff @(posedge clock) begin
      if (state_q == F_LOAD)
         val_q <= cur_val;
      if (upd_last)
         for (int i = 0; i < NUM_FIELDS; i++)
            if (fidx_q == FW'(i))
               last_q[i] <= val_q;
   end

   always_comb begin
      cl_start = '0;
      for (int i = 0; i < NUM_CLIENTS; i++)
         cl_start[i] = (state_q == C_START) && (cidx_q == CW'(i));
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign busy        = (state_q != IDLE);
   assign sweep_done  = (state_q == DONE);
   assign timeout_err = terr_q;

endmodule
